// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control types for the 5-stage core: the hazard unit state
// encoding and the width of its memory-wait counter.
package riscv_pipe_pkg;
  localparam int HZ_WAIT_CNT_W = 8;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_WAIT = 1'b1
  } hz_state_t;
endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall and branch-flush performance counters for hazard_unit; both wrap
// modulo 2^32 and clear on rst.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_inc};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: memory freeze, branch flush, load-use stall.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        if_id_uses_rs1,
  input  logic        if_id_uses_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_MR,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        mem_wb_bubble,
  output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam logic [HZ_WAIT_CNT_W-1:0] TIMEOUT_C = HZ_WAIT_CNT_W'(MEM_TIMEOUT);

  hz_state_t                state_q, state_d;
  logic [HZ_WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                     mem_err_q, mem_err_d;
  logic                     freeze, abort, load_use;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    abort      = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (mem_req && !mem_ready) begin
          freeze     = 1'b1;
          state_d    = HZ_WAIT;
          wait_cnt_d = HZ_WAIT_CNT_W'(1);
        end
      end
      HZ_WAIT: begin
        if (mem_ready) begin
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < TIMEOUT_C) begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + HZ_WAIT_CNT_W'(1);
        end else begin
          abort      = 1'b1;
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = HZ_RUN;
        wait_cnt_d = '0;
      end
    endcase
    mem_err_d = abort;

    load_use = id_ex_MR && (id_ex_rd != 5'd0) &&
               ((if_id_uses_rs1 && (id_ex_rd == if_id_rs1)) ||
                (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b1 & 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      // reset forces defaults; the state register clears on this edge
    end else if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (abort) begin
      // Let the pipeline advance but drop the faulting MEM instruction.
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .stall_inc (!pc_write),
    .flush_inc (if_id_flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MEM_TIMEOUT = 4).
module tb_hazard_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_uses_rs1, if_id_uses_rs2, id_ex_MR;
  logic       ex_branch_taken, mem_req, mem_ready;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic       if_id_flush, id_ex_bubble, mem_wb_bubble, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] base_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble, mem_wb_bubble}
  logic [6:0] outs;
  assign outs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 if_id_flush, id_ex_bubble, mem_wb_bubble};

  localparam logic [6:0] O_DEF = 7'b1111_000;
  localparam logic [6:0] O_FRZ = 7'b0000_001;
  localparam logic [6:0] O_BR  = 7'b1111_110;
  localparam logic [6:0] O_LU  = 7'b0011_010;
  localparam logic [6:0] O_AB  = 7'b1111_001;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .if_id_uses_rs1  (if_id_uses_rs1),
    .if_id_uses_rs2  (if_id_uses_rs2),
    .id_ex_rd        (id_ex_rd),
    .id_ex_MR        (id_ex_MR),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_err         (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  task automatic idle();
    if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rd = 0;
    if_id_uses_rs1 = 0; if_id_uses_rs2 = 0; id_ex_MR = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_ex_MR = 1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7; if_id_uses_rs1 = 1;
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, O_DEF); end
    tick();
    n_checks++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    idle();
    rst = 1'b0;
    #1;
    $display("[%0t] reset done outs=%b", $time, outs);
  endtask

  task automatic test_load_use();
    id_ex_MR = 1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_uses_rs2 = 1;
    #1;
    n_checks++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL load_use_rs2: got %b want %b", outs, O_LU); end
    tick();
    id_ex_MR = 0;  // bubble has cleared the load marker in EX
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL load_use_release: got %b want %b", outs, O_DEF); end
    idle();
    id_ex_MR = 1; id_ex_rd = 5'd9; if_id_rs1 = 5'd9; if_id_uses_rs1 = 1;
    #1;
    n_checks++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL load_use_rs1: got %b want %b", outs, O_LU); end
    tick();
    idle();
    $display("[%0t] load-use stall checked", $time);
  endtask

  task automatic test_no_false_stall();
    id_ex_MR = 1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_uses_rs1 = 1;
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL no_stall_x0: got %b want %b", outs, O_DEF); end
    id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_uses_rs1 = 0;
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL no_stall_unused: got %b want %b", outs, O_DEF); end
    id_ex_MR = 0; if_id_uses_rs1 = 1;
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL no_stall_not_load: got %b want %b", outs, O_DEF); end
    tick();
    idle();
    $display("[%0t] no false stall checked", $time);
  endtask

  task automatic test_branch();
`ifdef HAZARD_PERF_CNT_EN
    base_cnt = flush_cnt;
`endif
    ex_branch_taken = 1;
    id_ex_MR = 1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_uses_rs2 = 1;
    #1;
    n_checks++;
    if (outs !== O_BR) begin n_fail++; $display("FAIL branch_over_lu: got %b want %b", outs, O_BR); end
    tick();
    idle();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (flush_cnt !== base_cnt + 32'd1) begin
      n_fail++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt, base_cnt + 32'd1);
    end
`endif
    $display("[%0t] branch flush checked", $time);
  endtask

  task automatic test_mem_wait();
`ifdef HAZARD_PERF_CNT_EN
    base_cnt = stall_cnt;
`endif
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (outs !== O_FRZ) begin n_fail++; $display("FAIL mem_wait_frz%0d: got %b want %b", c, outs, O_FRZ); end
      tick();
    end
    mem_ready = 1;
    ex_branch_taken = 1;  // ready cycle unfreezes; branch now acts
    #1;
    n_checks++;
    if (outs !== O_BR) begin n_fail++; $display("FAIL mem_wait_ready: got %b want %b", outs, O_BR); end
    tick();
    idle();
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL mem_wait_run: got %b want %b", outs, O_DEF); end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (stall_cnt !== base_cnt + 32'd3) begin
      n_fail++; $display("FAIL mem_wait_stall_cnt: got %0d want %0d", stall_cnt, base_cnt + 32'd3);
    end
`endif
    $display("[%0t] memory wait checked", $time);
  endtask

  task automatic test_timeout();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (outs !== O_FRZ) begin n_fail++; $display("FAIL timeout_frz%0d: got %b want %b", c, outs, O_FRZ); end
      tick();
    end
    #1;
    n_checks++;
    if (outs !== O_AB || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_abort: got %b err=%b want %b err=0", outs, mem_err, O_AB);
    end
    tick();
    mem_req = 0;
    #1;
    n_checks++;
    if (outs !== O_DEF || mem_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_err: got %b err=%b want %b err=1", outs, mem_err, O_DEF);
    end
    tick();
    n_checks++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b want 0", mem_err); end
    idle();
    $display("[%0t] timeout abort checked", $time);
  endtask

  task automatic test_reset_mid_wait();
    mem_req = 1; mem_ready = 0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL rst_wait_outs: got %b want %b", outs, O_DEF); end
    tick();
    rst = 1'b0;
    mem_req = 0; mem_ready = 0;
    #1;
    n_checks++;
    if (outs !== O_DEF || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_run: got %b err=%b want %b err=0", outs, mem_err, O_DEF);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_wait_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    tick();
    idle();
    $display("[%0t] reset mid-wait checked", $time);
  endtask

  task automatic test_ready_same_cycle();
    mem_req = 1; mem_ready = 1;
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL ready_same: got %b want %b", outs, O_DEF); end
    tick();
    mem_req = 0; mem_ready = 0;
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL ready_same_state: got %b want %b", outs, O_DEF); end
    tick();
    idle();
    $display("[%0t] same-cycle ready checked", $time);
  endtask

  task automatic test_back_to_back();
    // two dependent loads: each stalls once, with a bubble cycle between
    id_ex_MR = 1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3; if_id_uses_rs1 = 1;
    #1;
    n_checks++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL b2b_first: got %b want %b", outs, O_LU); end
    tick();
    id_ex_MR = 0;
    #1;
    n_checks++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL b2b_bubble: got %b want %b", outs, O_DEF); end
    tick();
    id_ex_MR = 1; id_ex_rd = 5'd4; if_id_rs2 = 5'd4; if_id_uses_rs2 = 1;
    #1;
    n_checks++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL b2b_second: got %b want %b", outs, O_LU); end
    tick();
    idle();
    $display("[%0t] back-to-back loads checked", $time);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_ready_same_cycle();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
